// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM state encoding, direction constants and default floor count.
package elevator_pkg;
   typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR_OPEN} state_t;
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   localparam int DEF_BUTTONS_WIDTH = 8;
endpackage

// File: rtl/elevator_ctrl_request_scan.sv
// request_scan: classifies pending requests relative to the car floor.
//   req   : combined request vector, one bit per floor
//   floor : current car floor
//   above/below/here : any request strictly above, strictly below, or at floor
module request_scan
   import elevator_pkg::*;
#(
   parameter int W = DEF_BUTTONS_WIDTH,
   localparam int FW = $clog2(W)
) (
   input  logic [W-1:0]  req,
   input  logic [FW-1:0] floor,
   output logic          above,
   output logic          below,
   output logic          here
);
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < W; i++) begin
         above = above | (req[i] & (i > int'(floor)));
         below = below | (req[i] & (i < int'(floor)));
      end
      here = req[floor];
   end
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN car-motion and door controller returning clear pulses for served requests.
//   clk, reset                : clock, async active-high reset
//   active_*_levels           : latched cabin / hall-up / hall-down requests
//   inactivate_*_levels       : one-cycle one-hot clear pulses, issued on door opening
//   floor, dir_up, moving, door_open : registered car status
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
   parameter int FLOOR_TICKS = 4,
   parameter int DOOR_TICKS = 6,
   localparam int FW = $clog2(BUTTONS_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
   input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
   input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
   output logic [FW-1:0]            floor,
   output logic                     dir_up,
   output logic                     moving,
   output logic                     door_open
);
   localparam int MT = FLOOR_TICKS > DOOR_TICKS ? FLOOR_TICKS : DOOR_TICKS;
   localparam int CW = $clog2(MT + 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [BUTTONS_WIDTH-1:0] req, hot;
   logic above, below, here, ahead, stop, d_eff, clr_both;
   request_scan #(.W(BUTTONS_WIDTH)) u_scan (
      .req(req), .floor(floor), .above(above), .below(below), .here(here)
   );
   always_comb begin
      req = active_in_levels | active_out_up_levels | active_out_down_levels;
      hot = BUTTONS_WIDTH'(1) << floor;
      ahead = dir_up ? above : below;
      stop = active_in_levels[floor] | (dir_up & active_out_up_levels[floor]) |
             (!dir_up & active_out_down_levels[floor]) | (!ahead & here);
      d_eff = ahead ? dir_up : !dir_up;
      // end of run with nothing left in the new direction: both hall calls here are satisfied
      clr_both = !ahead & !(d_eff ? above : below);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         floor <= '0;
         dir_up <= DIR_UP;
         moving <= 1'b0;
         door_open <= 1'b0;
         cnt <= '0;
         inactivate_in_levels <= '0;
         inactivate_out_up_levels <= '0;
         inactivate_out_down_levels <= '0;
      end else begin
         inactivate_in_levels <= '0;
         inactivate_out_up_levels <= '0;
         inactivate_out_down_levels <= '0;
         case (state)
            IDLE:
               if (here) begin
                  state <= DOOR_OPEN;
                  door_open <= 1'b1;
                  cnt <= '0;
                  inactivate_in_levels <= hot;
                  inactivate_out_up_levels <= hot;
                  inactivate_out_down_levels <= hot;
               end else if (above | below) begin
                  state <= MOVE;
                  moving <= 1'b1;
                  dir_up <= above ? DIR_UP : DIR_DOWN;
                  cnt <= '0;
               end
            MOVE:
               if (cnt == CW'(FLOOR_TICKS - 1)) begin
                  state <= ARRIVE;
                  moving <= 1'b0;
                  cnt <= '0;
                  floor <= dir_up ? floor + FW'(1) : floor - FW'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            ARRIVE:
               if (stop) begin
                  state <= DOOR_OPEN;
                  door_open <= 1'b1;
                  dir_up <= d_eff;
                  inactivate_in_levels <= hot;
                  inactivate_out_up_levels <= (d_eff | clr_both) ? hot : '0;
                  inactivate_out_down_levels <= (!d_eff | clr_both) ? hot : '0;
               end else if (ahead) begin
                  state <= MOVE;
                  moving <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            DOOR_OPEN:
               if (cnt == CW'(DOOR_TICKS - 1)) begin
                  state <= IDLE;
                  door_open <= 1'b0;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: scoreboard bench for elevator_ctrl with a latching request-block model.
module tb_elevator_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] in_r = '0, up_r = '0, dn_r = '0;
   logic [7:0] ii, iu, id;
   logic [2:0] floor;
   logic dir_up, moving, door_open;
   int n_cmp = 0, n_err = 0;
   typedef struct {
      logic [2:0] f;
      logic [7:0] i, u, d;
      logic dir;
   } ev_t;
   ev_t sb[$];
   ev_t e_m;

   elevator_ctrl #(.BUTTONS_WIDTH(8), .FLOOR_TICKS(4), .DOOR_TICKS(6)) dut (
      .clk(clk), .reset(reset),
      .active_in_levels(in_r), .active_out_up_levels(up_r), .active_out_down_levels(dn_r),
      .inactivate_in_levels(ii), .inactivate_out_up_levels(iu), .inactivate_out_down_levels(id),
      .floor(floor), .dir_up(dir_up), .moving(moving), .door_open(door_open)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] f, input logic [7:0] i, u, d, input logic dir);
      ev_t e;
      e.f = f; e.i = i; e.u = u; e.d = d; e.dir = dir;
      sb.push_back(e);
   endtask

   // Served-request monitor: every pulse must match the next expected service event,
   // and the request block drops the served bits one cycle later.
   always @(negedge clk) begin
      if (!reset && (ii | iu | id) != 8'h00) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {8'h00, ii, iu, id}, 32'h0);
         end else begin
            e_m = sb.pop_front();
            check("pulse_floor", floor, e_m.f);
            check("pulse_in", ii, e_m.i);
            check("pulse_up", iu, e_m.u);
            check("pulse_dn", id, e_m.d);
            check("pulse_dir", dir_up, e_m.dir);
            check("pulse_door", door_open, 1);
         end
         in_r = in_r & ~ii;
         up_r = up_r & ~iu;
         dn_r = dn_r & ~id;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      in_r = '0; up_r = '0; dn_r = '0;
      sb.delete();
      @(negedge clk);
      check("rst_floor", floor, 0);
      check("rst_dir", dir_up, 1);
      check("rst_moving", moving, 0);
      check("rst_door", door_open, 0);
      check("rst_pulses", {ii, iu, id}, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic settle();
      int lows = 0;
      int i;
      for (i = 0; i < 600; i++) begin
         if (lows >= 3 && sb.size() == 0) break;
         @(negedge clk);
         lows = (!moving && !door_open) ? lows + 1 : 0;
      end
      check("settle_timeout", i < 600, 1);
   endtask

   task automatic wait_floor(input logic [2:0] f, input logic mv);
      int i;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (floor == f && moving == mv) break;
      end
      check("wait_floor_timeout", i < 100, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      @(negedge clk);
      // single cabin call to floor 3: travel latency and door dwell
      do_reset();
      in_r = 8'h08;
      push(3, 8'h08, 8'h08, 8'h08, 0);
      n = 0;
      while (!door_open && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("lat_3_floors", n, 16);
      check("arrive_floor3", floor, 3);
      n = 0;
      while (door_open && n < 60) begin
         n++;
         @(negedge clk);
      end
      check("door_dwell", n, 6);
      settle();
      check("idle_floor3", floor, 3);
      check("idle_moving", moving, 0);

      // call at the current floor opens the door on the next cycle
      do_reset();
      up_r = 8'h01;
      push(0, 8'h01, 8'h01, 8'h01, 1);
      @(negedge clk);
      check("here_door", door_open, 1);
      settle();

      // direction-aware stops on an up run, then reversal to serve down[2]
      do_reset();
      in_r = 8'h80; dn_r = 8'h04; up_r = 8'h10;
      push(4, 8'h10, 8'h10, 8'h00, 1);
      push(7, 8'h80, 8'h00, 8'h80, 0);
      push(2, 8'h04, 8'h04, 8'h04, 1);
      wait_floor(2, 0);
      check("pass2_door", door_open, 0);
      check("pass2_dir", dir_up, 1);
      @(negedge clk);
      check("pass2_resume", moving, 1);
      settle();
      check("scan_end_floor", floor, 2);

      // end-of-run reversal at floor 5
      do_reset();
      dn_r = 8'h20;
      push(5, 8'h20, 8'h20, 8'h20, 0);
      settle();
      check("rev5_dir", dir_up, 0);
      check("rev5_floor", floor, 5);

      // top floor: only below requests make the car head down; floor 0 holds still
      do_reset();
      in_r = 8'h80;
      push(7, 8'h80, 8'h80, 8'h80, 0);
      settle();
      check("top_floor", floor, 7);
      in_r = 8'h01;
      push(0, 8'h01, 8'h01, 8'h01, 1);
      @(negedge clk);
      check("top_dir_down", dir_up, 0);
      check("top_moving", moving, 1);
      settle();
      check("bottom_floor", floor, 0);
      repeat (5) @(negedge clk);
      check("bottom_hold_floor", floor, 0);
      check("bottom_hold_moving", moving, 0);

      // reset while moving from 2 to 3; request is re-served after release
      do_reset();
      in_r = 8'h08;
      wait_floor(2, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_floor", floor, 0);
      check("mid_rst_moving", moving, 0);
      @(negedge clk);
      check("mid_rst_floor_cyc", floor, 0);
      check("mid_rst_moving_cyc", moving, 0);
      check("mid_rst_door", door_open, 0);
      check("mid_rst_pulses", {ii, iu, id}, 0);
      check("mid_rst_dir", dir_up, 1);
      reset = 1'b0;
      push(3, 8'h08, 8'h08, 8'h08, 0);
      settle();
      check("reserve_floor", floor, 3);

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car motion and door controller that consumes the latched hall and cabin requests from the button-request block and returns one-cycle clear pulses for served requests. It is the consumer end of the request interface, with active levels in and inactivate levels out. It runs a collective (SCAN) policy over `BUTTONS_WIDTH` floors, times travel and door dwell with counters, and reports car position, direction and door state to the top level.

## Interface
- `BUTTONS_WIDTH`, 8: number of floors; floor index width is `FW = $clog2(BUTTONS_WIDTH)`.
- `FLOOR_TICKS`, 4: cycles spent in MOVE per floor travelled (≥1).
- `DOOR_TICKS`, 6: cycles the door stays open (≥1).

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `active_in_levels` in `BUTTONS_WIDTH`: pending cabin requests, one bit per floor.
- `active_out_up_levels` in `BUTTONS_WIDTH`: pending hall-up calls.
- `active_out_down_levels` in `BUTTONS_WIDTH`: pending hall-down calls.
- `inactivate_in_levels` out `BUTTONS_WIDTH`: one-cycle clear pulse for cabin requests.
- `inactivate_out_up_levels` out `BUTTONS_WIDTH`: one-cycle clear pulse for hall-up calls.
- `inactivate_out_down_levels` out `BUTTONS_WIDTH`: one-cycle clear pulse for hall-down calls.
- `floor` out `FW`: current car floor.
- `dir_up` out 1: 1 means up, 0 means down.
- `moving` out 1: high in MOVE.
- `door_open` out 1: high in DOOR_OPEN.

## Operation
- **Combined request:** `req = in | up | down`.
  - `here = req[floor]`.
  - `above` = any `req` bit with index > `floor`.
  - `below` = any `req` bit with index < `floor`.
- **IDLE:**
  - If `here`: go to DOOR_OPEN and clear all three request bits at `floor`.
  - Else if `above`: set `dir_up=1` and go to MOVE.
  - Else if `below`: set `dir_up=0` and go to MOVE.
  - `above` has priority over `below`.
- **MOVE:** the counter runs `FLOOR_TICKS` cycles. On the last cycle, `floor ± 1` per `dir_up`, then go to ARRIVE.
- **ARRIVE** (one cycle). Let `ahead = dir_up ? above : below`.
  - Stop if any of these holds: `in[floor]`; `dir_up & up[floor]`; `!dir_up & down[floor]`; `!ahead & here`.
  - On stop, the effective direction is `d' = ahead ? dir_up : !dir_up`. `dir_up` takes `d'` only if `!ahead`.
  - On stop, clear `in[floor]`. Clear `up[floor]` if `d'` is up, or `down[floor]` if `d'` is down. If `!ahead` and there is no request in the `d'` direction either, clear both hall bits.
  - Then go to DOOR_OPEN.
  - No stop and `ahead`: go to MOVE.
  - No stop and `!ahead`: go to IDLE.
- **DOOR_OPEN:** the counter runs `DOOR_TICKS` cycles, then go to IDLE.
- **Floor range:** the car never moves past floor 0 or `BUTTONS_WIDTH-1`. `above` is structurally 0 at the top floor and `below` is 0 at floor 0. No wrap-around.
- **Requests raised mid-MOVE:** evaluated only at the next ARRIVE or IDLE.
- **Requests during DOOR_OPEN:** a request at the current floor raised during DOOR_OPEN is served by the IDLE re-check, which reopens the door.

## Timing
- **Reset values:** state IDLE, `floor=0`, `dir_up=1`, `moving=0`, `door_open=0`, all inactivate outputs 0, counters 0.
- **Reset mid-operation:** same values; the car snaps to floor 0.
- **Registered outputs:** all outputs are registered. Inactivate pulses are asserted in the first DOOR_OPEN cycle, for exactly 1 cycle, and are one-hot at `floor`.
- **Travel latency:** IDLE decision takes 1 cycle. Each floor takes `FLOOR_TICKS` + 1 ARRIVE cycle, so travelling k floors from IDLE takes 1 + k·(FLOOR_TICKS+1) cycles to the DOOR_OPEN entry.
- **Door dwell:** `door_open` is high for exactly `DOOR_TICKS` cycles.
- **Request handshake:** the upstream block clears the bit one cycle after the pulse. The controller never re-serves a bit within DOOR_OPEN.
- **Pass-through floors:** ARRIVE at a floor with no stop keeps `moving` low for that single cycle.

## Structure
- **Shared package `elevator_pkg`:**
  - State enum `{IDLE, MOVE, ARRIVE, DOOR_OPEN}`.
  - `DIR_UP`/`DIR_DOWN` constants.
  - Default `BUTTONS_WIDTH`.
- **Sub-module `request_scan`:** combinational. Takes `req` and `floor`; produces `above`, `below` and `here`. It is instantiated once.
- **Main module:** the FSM plus one shared tick counter, sized to max(`FLOOR_TICKS`, `DOOR_TICKS`).

## Test plan
- **Single cabin call:** reset, then `active_in_levels=8'h08`. Required: `floor` reaches 3 after 15 cycles in MOVE/ARRIVE; `inactivate_in_levels=8'h08` for 1 cycle; `door_open` high for 6 cycles; then IDLE at floor 3.
- **Call at the current floor:** at floor 0 idle, set `up=8'h01`. Required: DOOR_OPEN entered 1 cycle later; `inactivate_out_up_levels=8'h01`.
- **Direction-aware stops, up run:** from floor 0, `in=8'h80`, `down=8'h04`, `up=8'h10`. Required: stop at 4 (up pulse `8'h10`); pass floor 2 (ARRIVE, no pulse); stop at 7; then reverse and serve `down[2]`.
- **End-of-run reversal:** car at 5 moving up, only `down[5]` pending. Required: stop at 5 with `down` pulse `8'h20` and `dir_up=0`.
- **Top floor:** car at floor 7 with only `below` requests. Required: `dir_up=0`, `floor` never exceeds 7; the same holds for floor 0 with no `below`.
- **Reset mid-MOVE:** reset pulsed while moving from 2 to 3. Required: next cycle `floor=0`, `moving=0`, all pulses 0; the pending requests are re-served after release.
